// File: rtl/alu_unit.sv
// Registered arithmetic/logic unit with one cycle of latency.
// mode = 1 selects the arithmetic command set, mode = 0 the logical set.
// Each enabled edge writes every output: fields the selected command does
// not produce are cleared, and any illegal request returns only err = 1.
module alu_unit #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       opa,
  input  logic [WIDTH-1:0]       opb,
  input  logic                   cin,
  input  logic                   ce,
  input  logic                   mode,
  input  logic [CMD_WIDTH-1:0]   cmd,
  input  logic [1:0]             inp_valid,
  output logic [2*WIDTH-1:0]     res,
  output logic                   cout,
  output logic                   oflow,
  output logic                   g,
  output logic                   l,
  output logic                   e,
  output logic                   err
);

  // Rotate amount width; opb bits at or above this position make a rotate illegal.
  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [CMD_WIDTH-1:0] {
    A_ADD     = 0,
    A_SUB     = 1,
    A_ADD_CIN = 2,
    A_SUB_CIN = 3,
    A_INC_A   = 4,
    A_DEC_A   = 5,
    A_INC_B   = 6,
    A_DEC_B   = 7,
    A_CMP     = 8,
    A_MUL_INC = 9,
    A_MUL_SHL = 10
  } arith_cmd_e;

  typedef enum logic [CMD_WIDTH-1:0] {
    L_AND    = 0,
    L_NAND   = 1,
    L_OR     = 2,
    L_NOR    = 3,
    L_XOR    = 4,
    L_XNOR   = 5,
    L_NOT_A  = 6,
    L_NOT_B  = 7,
    L_SHR1_A = 8,
    L_SHL1_A = 9,
    L_SHR1_B = 10,
    L_SHL1_B = 11,
    L_ROL    = 12,
    L_ROR    = 13
  } logic_cmd_e;

  // Zero-extend a WIDTH-bit value to the result width.
  function automatic logic [2*WIDTH-1:0] zx_w(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

  // Zero-extend a WIDTH+1-bit value (carry included) to the result width.
  function automatic logic [2*WIDTH-1:0] zx_c(input logic [WIDTH:0] v);
    return {{(WIDTH-1){1'b0}}, v};
  endfunction

  // Widened operands and per-operation arithmetic results.
  logic [WIDTH:0]       a_ext;
  logic [WIDTH:0]       b_ext;
  logic [WIDTH:0]       c_ext;
  logic [WIDTH:0]       add_w;
  logic [WIDTH:0]       addc_w;
  logic [WIDTH:0]       sub_w;
  logic [WIDTH:0]       subc_w;
  logic [WIDTH:0]       inca_w;
  logic [WIDTH:0]       incb_w;
  logic [WIDTH:0]       deca_w;
  logic [WIDTH:0]       decb_w;
  logic [WIDTH:0]       a_inc;
  logic [WIDTH:0]       b_inc;
  logic [2*WIDTH-1:0]   mul_inc;
  logic [WIDTH-1:0]     a_shl;
  logic [2*WIDTH-1:0]   mul_shl;
  logic [SHW-1:0]       rot_amt;
  logic                 rot_high;
  logic [WIDTH-1:0]     rol_v;
  logic [WIDTH-1:0]     ror_v;

  // Next-state values for the output registers.
  logic [2*WIDTH-1:0]   res_n;
  logic                 cout_n;
  logic                 oflow_n;
  logic                 g_n;
  logic                 l_n;
  logic                 e_n;
  logic                 err_n;
  logic                 need_a;
  logic                 need_b;
  logic                 defined;
  logic                 illegal;

  // Shared datapath: every candidate result computed from the current operands.
  always_comb begin
    a_ext   = {1'b0, opa};
    b_ext   = {1'b0, opb};
    c_ext   = {{WIDTH{1'b0}}, cin};
    add_w   = a_ext + b_ext;
    addc_w  = a_ext + b_ext + c_ext;
    // The bit above the WIDTH-bit difference is the borrow, since the
    // true difference never goes below -2^WIDTH.
    sub_w   = a_ext - b_ext;
    subc_w  = a_ext - b_ext - c_ext;
    inca_w  = a_ext + {{WIDTH{1'b0}}, 1'b1};
    incb_w  = b_ext + {{WIDTH{1'b0}}, 1'b1};
    deca_w  = a_ext - {{WIDTH{1'b0}}, 1'b1};
    decb_w  = b_ext - {{WIDTH{1'b0}}, 1'b1};
    a_inc   = inca_w;
    b_inc   = incb_w;
    // Multiplying in the result width drops the bits above 2*WIDTH.
    mul_inc = zx_c(a_inc) * zx_c(b_inc);
    a_shl   = {opa[WIDTH-2:0], 1'b0};
    mul_shl = zx_w(a_shl) * zx_w(opb);
    rot_amt  = opb[SHW-1:0];
    rot_high = |(opb >> SHW);
    rol_v   = (opa << rot_amt) | (opa >> (WIDTH - int'(rot_amt)));
    ror_v   = (opa >> rot_amt) | (opa << (WIDTH - int'(rot_amt)));
  end

  // Command decode: operand requirements, legality and result selection.
  always_comb begin
    res_n   = '0;
    cout_n  = 1'b0;
    oflow_n = 1'b0;
    g_n     = 1'b0;
    l_n     = 1'b0;
    e_n     = 1'b0;
    err_n   = 1'b0;
    need_a  = 1'b1;
    need_b  = 1'b1;
    defined = 1'b1;
    illegal = 1'b0;

    if (mode) begin
      case (cmd)
        A_ADD: begin
          res_n  = zx_c(add_w);
          cout_n = add_w[WIDTH];
        end
        A_SUB: begin
          res_n   = zx_w(sub_w[WIDTH-1:0]);
          oflow_n = sub_w[WIDTH];
        end
        A_ADD_CIN: begin
          res_n  = zx_c(addc_w);
          cout_n = addc_w[WIDTH];
        end
        A_SUB_CIN: begin
          res_n   = zx_w(subc_w[WIDTH-1:0]);
          oflow_n = subc_w[WIDTH];
        end
        A_INC_A: begin
          need_b = 1'b0;
          res_n  = zx_c(inca_w);
          cout_n = inca_w[WIDTH];
        end
        A_DEC_A: begin
          need_b  = 1'b0;
          res_n   = zx_w(deca_w[WIDTH-1:0]);
          oflow_n = deca_w[WIDTH];
        end
        A_INC_B: begin
          need_a = 1'b0;
          res_n  = zx_c(incb_w);
          cout_n = incb_w[WIDTH];
        end
        A_DEC_B: begin
          need_a  = 1'b0;
          res_n   = zx_w(decb_w[WIDTH-1:0]);
          oflow_n = decb_w[WIDTH];
        end
        A_CMP: begin
          g_n = (opa > opb);
          l_n = (opa < opb);
          e_n = (opa == opb);
        end
        A_MUL_INC: res_n = mul_inc;
        A_MUL_SHL: res_n = mul_shl;
        default:   defined = 1'b0;
      endcase
    end else begin
      case (cmd)
        L_AND:    res_n = zx_w(opa & opb);
        L_NAND:   res_n = zx_w(~(opa & opb));
        L_OR:     res_n = zx_w(opa | opb);
        L_NOR:    res_n = zx_w(~(opa | opb));
        L_XOR:    res_n = zx_w(opa ^ opb);
        L_XNOR:   res_n = zx_w(~(opa ^ opb));
        L_NOT_A: begin
          need_b = 1'b0;
          res_n  = zx_w(~opa);
        end
        L_NOT_B: begin
          need_a = 1'b0;
          res_n  = zx_w(~opb);
        end
        L_SHR1_A: begin
          need_b = 1'b0;
          res_n  = zx_w(opa >> 1);
        end
        L_SHL1_A: begin
          need_b = 1'b0;
          res_n  = zx_w(opa << 1);
        end
        L_SHR1_B: begin
          need_a = 1'b0;
          res_n  = zx_w(opb >> 1);
        end
        L_SHL1_B: begin
          need_a = 1'b0;
          res_n  = zx_w(opb << 1);
        end
        L_ROL: begin
          illegal = rot_high;
          res_n   = zx_w(rol_v);
        end
        L_ROR: begin
          illegal = rot_high;
          res_n   = zx_w(ror_v);
        end
        default: defined = 1'b0;
      endcase
    end

    // Any failed qualification replaces the whole result with a bare error.
    if (!defined || illegal || (inp_valid == 2'b00) ||
        (need_a && !inp_valid[0]) || (need_b && !inp_valid[1])) begin
      res_n   = '0;
      cout_n  = 1'b0;
      oflow_n = 1'b0;
      g_n     = 1'b0;
      l_n     = 1'b0;
      e_n     = 1'b0;
      err_n   = 1'b1;
    end
  end

  // Output registers: synchronous reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      res   <= '0;
      cout  <= 1'b0;
      oflow <= 1'b0;
      g     <= 1'b0;
      l     <= 1'b0;
      e     <= 1'b0;
      err   <= 1'b0;
    end else if (ce) begin
      res   <= res_n;
      cout  <= cout_n;
      oflow <= oflow_n;
      g     <= g_n;
      l     <= l_n;
      e     <= e_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases from the command tables
// plus randomized traffic checked against an integer reference model.
module tb_alu_unit;

  localparam int WIDTH     = 8;
  localparam int CMD_WIDTH = 4;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        oflow;
    logic        g;
    logic        l;
    logic        e;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        m;
    logic [3:0]  cm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c;
    logic [1:0]  iv;
    exp_t        x;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic                 cin;
  logic                 ce;
  logic                 mode;
  logic [CMD_WIDTH-1:0] cmd;
  logic [1:0]           inp_valid;
  logic [2*WIDTH-1:0]   res;
  logic                 cout;
  logic                 oflow;
  logic                 g;
  logic                 l;
  logic                 e;
  logic                 err;

  int checks   = 0;
  int failures = 0;

  alu_unit #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH)) dut (
    .clk(clk), .rst(rst), .opa(opa), .opb(opb), .cin(cin), .ce(ce),
    .mode(mode), .cmd(cmd), .inp_valid(inp_valid),
    .res(res), .cout(cout), .oflow(oflow), .g(g), .l(l), .e(e), .err(err)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic [15:0] r, input logic co, input logic of,
                              input logic gg, input logic ll, input logic ee,
                              input logic er);
    exp_t x;
    x.res = r; x.cout = co; x.oflow = of; x.g = gg; x.l = ll; x.e = ee; x.err = er;
    return x;
  endfunction

  function automatic exp_t observed();
    return ex(res, cout, oflow, g, l, e, err);
  endfunction

  // Reference model: integer arithmetic straight from the command tables.
  function automatic exp_t model(input logic m, input logic [3:0] cm, input logic [7:0] a8,
                                 input logic [7:0] b8, input logic c1, input logic [1:0] iv);
    int a = int'(a8);
    int b = int'(b8);
    int c = int'(c1);
    int k = int'(cm);
    int need = 0;
    int r = 0;
    exp_t x = '0;
    if (m) begin
      if (k <= 3 || (k >= 8 && k <= 10)) need = 3;
      else if (k == 4 || k == 5) need = 1;
      else if (k == 6 || k == 7) need = 2;
    end else begin
      if (k <= 5 || k == 12 || k == 13) need = 3;
      else if (k == 6 || k == 8 || k == 9) need = 1;
      else if (k == 7 || k == 10 || k == 11) need = 2;
    end
    if (need == 0 || iv == 2'b00 || ((int'(iv) & need) != need) ||
        (!m && (k == 12 || k == 13) && b > 7)) begin
      x.err = 1'b1;
      return x;
    end
    if (m) begin
      case (k)
        0: begin r = a + b;         x.cout  = (r > 255); end
        1: begin r = (a - b) & 255; x.oflow = (a < b); end
        2: begin r = a + b + c;     x.cout  = (r > 255); end
        3: begin r = (a - b - c) & 255; x.oflow = (a < b + c); end
        4: begin r = a + 1;         x.cout  = (r > 255); end
        5: begin r = (a - 1) & 255; x.oflow = (a == 0); end
        6: begin r = b + 1;         x.cout  = (r > 255); end
        7: begin r = (b - 1) & 255; x.oflow = (b == 0); end
        8: begin x.g = (a > b); x.l = (a < b); x.e = (a == b); end
        9: r = ((a + 1) * (b + 1)) % 65536;
        default: r = ((a * 2) % 256) * b;
      endcase
    end else begin
      case (k)
        0: r = a & b;
        1: r = ~(a & b) & 255;
        2: r = a | b;
        3: r = ~(a | b) & 255;
        4: r = a ^ b;
        5: r = ~(a ^ b) & 255;
        6: r = ~a & 255;
        7: r = ~b & 255;
        8: r = a / 2;
        9: r = (a * 2) % 256;
        10: r = b / 2;
        11: r = (b * 2) % 256;
        12: r = ((a << b) | (a >> (8 - b))) & 255;
        default: r = ((a >> b) | (a << (8 - b))) & 255;
      endcase
    end
    x.res = r[15:0];
    return x;
  endfunction

  task automatic drive(input logic m, input logic [3:0] cm, input logic [7:0] a,
                       input logic [7:0] b, input logic c, input logic [1:0] iv);
    mode = m; cmd = cm; opa = a; opb = b; cin = c; inp_valid = iv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t got;
    exp_t held;
    rst = 1'b1; ce = 1'b1;
    drive(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11);
    tick();
    got = observed();
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_clear got=%h want=%h", got, exp_t'('0));
    end
    rst = 1'b0;
    tick();
    got = observed();
    held = ex(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== held) begin
      failures++;
      $display("FAIL first_add got=%h want=%h", got, held);
    end
    ce = 1'b0;
    drive(1'b1, 4'd1, 8'h05, 8'h0A, 1'b0, 2'b11);
    tick();
    tick();
    got = observed();
    checks++;
    if (got !== held) begin
      failures++;
      $display("FAIL ce_hold got=%h want=%h", got, held);
    end
    rst = 1'b1;
    tick();
    got = observed();
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL rst_over_ce got=%h want=%h", got, exp_t'('0));
    end
    rst = 1'b0; ce = 1'b1;
  endtask

  task automatic test_arith();
    vec_t v[7];
    exp_t got;
    v[0] = '{1'b1, 4'd1, 8'h05, 8'h0A, 1'b0, 2'b11, ex(16'h00FB, 0, 1, 0, 0, 0, 0)};
    v[1] = '{1'b1, 4'd2, 8'h7F, 8'h00, 1'b1, 2'b11, ex(16'h0080, 0, 0, 0, 0, 0, 0)};
    v[2] = '{1'b1, 4'd5, 8'h00, 8'h33, 1'b1, 2'b01, ex(16'h00FF, 0, 1, 0, 0, 0, 0)};
    v[3] = '{1'b1, 4'd0, 8'hFF, 8'hFF, 1'b1, 2'b11, ex(16'h01FE, 1, 0, 0, 0, 0, 0)};
    v[4] = '{1'b1, 4'd3, 8'h05, 8'h05, 1'b1, 2'b11, ex(16'h00FF, 0, 1, 0, 0, 0, 0)};
    v[5] = '{1'b1, 4'd6, 8'h00, 8'hFF, 1'b0, 2'b10, ex(16'h0100, 1, 0, 0, 0, 0, 0)};
    v[6] = '{1'b1, 4'd2, 8'hFF, 8'h00, 1'b1, 2'b11, ex(16'h0100, 1, 0, 0, 0, 0, 0)};
    foreach (v[i]) begin
      drive(v[i].m, v[i].cm, v[i].a, v[i].b, v[i].c, v[i].iv);
      tick();
      got = observed();
      checks++;
      if (got !== v[i].x) begin
        failures++;
        $display("FAIL arith[%0d] got=%h want=%h", i, got, v[i].x);
      end
    end
  endtask

  task automatic test_compare_mul();
    vec_t v[5];
    exp_t got;
    v[0] = '{1'b1, 4'd8, 8'h10, 8'h20, 1'b0, 2'b11, ex(16'h0000, 0, 0, 0, 1, 0, 0)};
    v[1] = '{1'b1, 4'd8, 8'h20, 8'h20, 1'b1, 2'b11, ex(16'h0000, 0, 0, 0, 0, 1, 0)};
    v[2] = '{1'b1, 4'd8, 8'h30, 8'h20, 1'b0, 2'b11, ex(16'h0000, 0, 0, 1, 0, 0, 0)};
    v[3] = '{1'b1, 4'd9, 8'hFF, 8'hFF, 1'b0, 2'b11, ex(16'h0000, 0, 0, 0, 0, 0, 0)};
    v[4] = '{1'b1, 4'd10, 8'h03, 8'h04, 1'b1, 2'b11, ex(16'h0018, 0, 0, 0, 0, 0, 0)};
    foreach (v[i]) begin
      drive(v[i].m, v[i].cm, v[i].a, v[i].b, v[i].c, v[i].iv);
      tick();
      got = observed();
      checks++;
      if (got !== v[i].x) begin
        failures++;
        $display("FAIL cmp_mul[%0d] got=%h want=%h", i, got, v[i].x);
      end
    end
  endtask

  task automatic test_logical();
    vec_t v[6];
    exp_t got;
    v[0] = '{1'b0, 4'd4, 8'hA5, 8'h0F, 1'b1, 2'b11, ex(16'h00AA, 0, 0, 0, 0, 0, 0)};
    v[1] = '{1'b0, 4'd6, 8'hA5, 8'h0F, 1'b1, 2'b01, ex(16'h005A, 0, 0, 0, 0, 0, 0)};
    v[2] = '{1'b0, 4'd12, 8'hA5, 8'h03, 1'b0, 2'b11, ex(16'h002D, 0, 0, 0, 0, 0, 0)};
    v[3] = '{1'b0, 4'd13, 8'hA5, 8'h10, 1'b0, 2'b11, ex(16'h0000, 0, 0, 0, 0, 0, 1)};
    v[4] = '{1'b0, 4'd13, 8'hA5, 8'h07, 1'b0, 2'b11, ex(16'h004B, 0, 0, 0, 0, 0, 0)};
    v[5] = '{1'b0, 4'd11, 8'h00, 8'hC3, 1'b0, 2'b10, ex(16'h0086, 0, 0, 0, 0, 0, 0)};
    foreach (v[i]) begin
      drive(v[i].m, v[i].cm, v[i].a, v[i].b, v[i].c, v[i].iv);
      tick();
      got = observed();
      checks++;
      if (got !== v[i].x) begin
        failures++;
        $display("FAIL logical[%0d] got=%h want=%h", i, got, v[i].x);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v[7];
    exp_t got;
    v[0] = '{1'b1, 4'd0, 8'h12, 8'h34, 1'b0, 2'b01, ex(16'h0000, 0, 0, 0, 0, 0, 1)};
    v[1] = '{1'b1, 4'd4, 8'h41, 8'h00, 1'b0, 2'b01, ex(16'h0042, 0, 0, 0, 0, 0, 0)};
    v[2] = '{1'b1, 4'd12, 8'h41, 8'h22, 1'b0, 2'b11, ex(16'h0000, 0, 0, 0, 0, 0, 1)};
    v[3] = '{1'b0, 4'd0, 8'hFF, 8'hFF, 1'b0, 2'b00, ex(16'h0000, 0, 0, 0, 0, 0, 1)};
    v[4] = '{1'b1, 4'd7, 8'h05, 8'h05, 1'b0, 2'b01, ex(16'h0000, 0, 0, 0, 0, 0, 1)};
    v[5] = '{1'b0, 4'd14, 8'h05, 8'h05, 1'b0, 2'b11, ex(16'h0000, 0, 0, 0, 0, 0, 1)};
    v[6] = '{1'b1, 4'd8, 8'h05, 8'h05, 1'b0, 2'b00, ex(16'h0000, 0, 0, 0, 0, 0, 1)};
    foreach (v[i]) begin
      drive(v[i].m, v[i].cm, v[i].a, v[i].b, v[i].c, v[i].iv);
      tick();
      got = observed();
      checks++;
      if (got !== v[i].x) begin
        failures++;
        $display("FAIL errors[%0d] got=%h want=%h", i, got, v[i].x);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got;
    exp_t want;
    logic [3:0] seq [6];
    logic m;
    seq = '{4'd0, 4'd8, 4'd1, 4'd12, 4'd9, 4'd3};
    for (int i = 0; i < 6; i++) begin
      m = i[0] ? 1'b0 : 1'b1;
      drive(m, seq[i], 8'(8'h3C + i), 8'(i + 1), 1'b1, 2'b11);
      want = model(m, seq[i], 8'(8'h3C + i), 8'(i + 1), 1'b1, 2'b11);
      tick();
      got = observed();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_random();
    exp_t got;
    exp_t want;
    logic m;
    logic [3:0] cm;
    logic [7:0] a;
    logic [7:0] b;
    logic c;
    logic [1:0] iv;
    drive(1'b0, 4'd2, 8'h00, 8'h00, 1'b0, 2'b11);
    ce = 1'b1;
    tick();
    want = model(1'b0, 4'd2, 8'h00, 8'h00, 1'b0, 2'b11);
    for (int i = 0; i < 400; i++) begin
      m  = 1'($urandom_range(0, 1));
      cm = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      c  = 1'($urandom_range(0, 1));
      iv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      ce = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      drive(m, cm, a, b, c, iv);
      if (ce) want = model(m, cm, a, b, c, iv);
      tick();
      got = observed();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random[%0d] m=%0d cmd=%0d a=%h b=%h cin=%0d iv=%b ce=%0d got=%h want=%h",
                 i, m, cm, a, b, c, iv, ce, got, want);
      end
    end
    ce = 1'b1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
    test_reset();
    test_arith();
    test_compare_mul();
    test_logical();
    test_errors();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
